vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised VGA/raster timing generator. It produces hsync, vsync, a display-enable and zero-based pixel coordinates for any mode described by porch/sync/active parameters. It replaces the fixed 640x480 generator and adds:
- programmable sync polarity
- a clock enable
- registered, mutually aligned outputs
- line/frame start strobes

It sits between the pixel-clock source and the pixel/image-fetch logic feeding the DAC.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level
CW, 10, coordinate/counter width; H_TOTAL-1 and V_TOTAL-1 must fit in CW bits (elaboration check)

Ports:
pclk  in  1  pixel clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
en  in  1  clock enable; 0 freezes timing
hsync  out  1  horizontal sync, level per HS_POL
vsync  out  1  vertical sync, level per VS_POL
valid  out  1  1 while inside the active area
h_cnt  out  CW  pixel column in active area, else 0
v_cnt  out  CW  pixel row in active area, else 0
line_start  out  1  one-cycle strobe at x=0 of every line
frame_start  out  1  one-cycle strobe at x=0,y=0
frame_cnt  out  16  completed-frame count (only with VGA_TIMING_FRAME_CNT_EN)

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Internal counters x in 0..H_TOTAL-1 and y in 0..V_TOTAL-1. Within a line the order is: active, front porch, sync, back porch. Frames use the same order.
- Reset (reset low, async):
  - x=0, y=0
  - hsync=~HS_POL, vsync=~VS_POL
  - valid=0, h_cnt=0, v_cnt=0
  - line_start=0, frame_start=0, frame_cnt=0
- Counting, on each pclk edge with en=1:
  - x increments.
  - At x=H_TOTAL-1, x wraps to 0 and y increments.
  - At x=H_TOTAL-1 and y=V_TOTAL-1, both wrap to 0.
- All outputs are registered and decoded from the pre-increment (x,y). Latency is exactly 1 enabled cycle. All outputs always describe the same (x,y).
- Output decode:
  - valid = (x<H_ACTIVE)&&(y<V_ACTIVE).
  - h_cnt = x when x<H_ACTIVE, else 0. v_cnt = y when y<V_ACTIVE, else 0. Each axis is independent of the other axis.
  - hsync active when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC.
  - vsync active when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC. vsync therefore changes only on the cycle that reports x=0.
  - line_start = (x==0). frame_start = (x==0 && y==0).
- en=0:
  - Counters and all level outputs hold.
  - line_start and frame_start are forced to 0 on that cycle, so a strobe is never stretched.
  - Re-asserting en resumes from the held position.
- Reset mid-frame: immediate return to the reset values. The first enabled edge after release reports (0,0) with valid=1, line_start=1 and frame_start=1.
- Zero-width porch parameters are legal. A zero sync width is illegal (elaboration check).

Optional Feature:
VGA_TIMING_FRAME_CNT_EN:
- Defined: port frame_cnt[15:0] exists. It increments, registered, on the same edge that outputs frame_start=1, except the first frame_start after reset. It wraps 0xFFFF->0 and holds while en=0.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package vga_timing_pkg holds:
  - default 640x480@60 constants (the H/V active, porch and sync values above)
  - the derived H_TOTAL/V_TOTAL functions
  - CW default
  - an 800x600 constant set for reuse
- Sub-module vga_axis_counter: one wrapping counter with carry-in/carry-out, active-window decode and sync-window decode. It is instantiated twice; the horizontal instance's carry-out drives the vertical instance's carry-in.

Test Plan:
- Reset release, en=1, defaults: cycle 1 reports valid=1, h_cnt=0, v_cnt=0, frame_start=1, line_start=1. Cycle 640 reports h_cnt=639. Cycle 641 reports valid=0, h_cnt=0.
- Defaults, one line: hsync low exactly on cycles 657..752 (96 cycles). line_start repeats every 800 cycles.
- Defaults, full frame: vsync low for exactly 1600 cycles, starting at the cycle reporting x=0,y=490. frame_start period is 420000 cycles. v_cnt reaches 479 and never exceeds it.
- HS_POL=1, VS_POL=1, H_ACTIVE=8, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1:
  - hsync high on x=9,10
  - vsync high on y=5 for 12 cycles
  - 84-cycle frame period
- en toggled 0 for 5 cycles at x=0: outputs hold, line_start=0 during the stall, the strobe appears exactly once afterwards. Async reset low at x=300,y=200: outputs reach reset values before the next pclk edge.
- With VGA_TIMING_FRAME_CNT_EN on the small mode above: frame_cnt=0 during the first frame, 1 after 84 cycles, 3 after 252 cycles.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Mode constants and derived totals for the raster timing generator.
// Shared by vga_axis_counter and vga_timing_gen.
package vga_timing_pkg;

  localparam int unsigned CW_DEF = 10;

  localparam int unsigned H_ACTIVE_640 = 640;
  localparam int unsigned H_FP_640     = 16;
  localparam int unsigned H_SYNC_640   = 96;
  localparam int unsigned H_BP_640     = 48;
  localparam int unsigned V_ACTIVE_640 = 480;
  localparam int unsigned V_FP_640     = 10;
  localparam int unsigned V_SYNC_640   = 2;
  localparam int unsigned V_BP_640     = 33;

  localparam int unsigned H_ACTIVE_800 = 800;
  localparam int unsigned H_FP_800     = 40;
  localparam int unsigned H_SYNC_800   = 128;
  localparam int unsigned H_BP_800     = 88;
  localparam int unsigned V_ACTIVE_800 = 600;
  localparam int unsigned V_FP_800     = 1;
  localparam int unsigned V_SYNC_800   = 4;
  localparam int unsigned V_BP_800     = 23;
  localparam int unsigned CW_800       = 11;
  localparam bit          HS_POL_800   = 1'b1;
  localparam bit          VS_POL_800   = 1'b1;

  function automatic int unsigned axis_total(
    input int unsigned act,
    input int unsigned fp,
    input int unsigned sync,
    input int unsigned bp
  );
    return act + fp + sync + bp;
  endfunction

  function automatic int unsigned h_total(
    input int unsigned act,
    input int unsigned fp,
    input int unsigned sync,
    input int unsigned bp
  );
    return axis_total(act, fp, sync, bp);
  endfunction

  function automatic int unsigned v_total(
    input int unsigned act,
    input int unsigned fp,
    input int unsigned sync,
    input int unsigned bp
  );
    return axis_total(act, fp, sync, bp);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter, carry in/out, window decode.
// Ports: clk, rst_n, cin -> pos, cout, act, sync_win, first.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = H_ACTIVE_640,
  parameter int unsigned FP     = H_FP_640,
  parameter int unsigned SYNC   = H_SYNC_640,
  parameter int unsigned BP     = H_BP_640,
  parameter int unsigned CW     = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cin,
  output logic [CW-1:0] pos,
  output logic          cout,
  output logic          act,
  output logic          sync_win,
  output logic          first
);

  localparam int unsigned TOTAL =
    axis_total(ACTIVE, FP, SYNC, BP);
  localparam int unsigned SYNC_LO = ACTIVE + FP;
  localparam int unsigned SYNC_HI = SYNC_LO + SYNC;
  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

  if (SYNC == 0) begin : g_bad_sync
    $error("vga_axis_counter: sync width must be nonzero");
  end
  if (longint'(TOTAL) > (longint'(1) << CW)) begin : g_bad_cw
    $error("vga_axis_counter: TOTAL-1 does not fit in CW bits");
  end

  logic [CW-1:0] pos_q, pos_d;
  logic [31:0]   pos_w;

  always_comb begin
    pos_d = pos_q;
    cout  = 1'b0;
    if (cin) begin
      if (pos_q == LAST) begin
        pos_d = '0;
        cout  = 1'b1;
      end else begin
        pos_d = pos_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pos_q <= '0;
    else        pos_q <= pos_d;
  end

  assign pos_w    = 32'(pos_q);
  assign pos      = pos_q;
  assign act      = pos_w < ACTIVE;
  assign sync_win = (pos_w >= SYNC_LO) && (pos_w < SYNC_HI);
  assign first    = pos_q == '0;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with registered, aligned outputs.
// Optional completed-frame counter port when VGA_TIMING_FRAME_CNT_EN is set.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_640,
  parameter int unsigned H_FP     = H_FP_640,
  parameter int unsigned H_SYNC   = H_SYNC_640,
  parameter int unsigned H_BP     = H_BP_640,
  parameter int unsigned V_ACTIVE = V_ACTIVE_640,
  parameter int unsigned V_FP     = V_FP_640,
  parameter int unsigned V_SYNC   = V_SYNC_640,
  parameter int unsigned V_BP     = V_BP_640,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CW       = CW_DEF
) (
  input  logic          pclk,
  input  logic          reset,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          valid,
  output logic [CW-1:0] h_cnt,
  output logic [CW-1:0] v_cnt,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  logic [CW-1:0] h_pos, v_pos;
  logic h_cout, h_act, h_sync, h_first;
  logic v_wrap_unused, v_act, v_sync, v_first;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC),
    .BP(H_BP), .CW(CW)
  ) u_h (
    .clk(pclk), .rst_n(reset), .cin(en),
    .pos(h_pos), .cout(h_cout), .act(h_act),
    .sync_win(h_sync), .first(h_first)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC),
    .BP(V_BP), .CW(CW)
  ) u_v (
    .clk(pclk), .rst_n(reset), .cin(h_cout),
    .pos(v_pos), .cout(v_wrap_unused), .act(v_act),
    .sync_win(v_sync), .first(v_first)
  );

  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          valid_q, valid_d;
  logic [CW-1:0] h_cnt_q, h_cnt_d;
  logic [CW-1:0] v_cnt_q, v_cnt_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  // Strobes default low so a stall never stretches them.
  always_comb begin
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    valid_d       = valid_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (en) begin
      hsync_d       = h_sync ? HS_POL : ~HS_POL;
      vsync_d       = v_sync ? VS_POL : ~VS_POL;
      valid_d       = h_act && v_act;
      h_cnt_d       = h_act ? h_pos : '0;
      v_cnt_d       = v_act ? v_pos : '0;
      line_start_d  = h_first;
      frame_start_d = h_first && v_first;
    end
  end

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      valid_q       <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      valid_q       <= valid_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign valid       = valid_q;
  assign h_cnt       = h_cnt_q;
  assign v_cnt       = v_cnt_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        seen_q, seen_d;

  // The first frame_start after reset opens a frame, it completes none.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    seen_d      = seen_q;
    if (en && h_first && v_first) begin
      seen_d = 1'b1;
      if (seen_q) frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      frame_cnt_q <= '0;
      seen_q      <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      seen_q      <= seen_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 line timing and a tiny 12x7 mode.
// Covers reset, decode windows, strobes, stalls and async reset.
module tb_vga_timing_gen;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic rst_a, en_a, rst_b, en_b;
  logic hs_a, vs_a, val_a, ls_a, fs_a;
  logic hs_b, vs_b, val_b, ls_b, fs_b;
  logic [9:0] hc_a, vc_a, hc_b, vc_b;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] fc_a, fc_b;
`endif

  vga_timing_gen u_a (
    .pclk(pclk), .reset(rst_a), .en(en_a),
    .hsync(hs_a), .vsync(vs_a), .valid(val_a),
    .h_cnt(hc_a), .v_cnt(vc_a),
    .line_start(ls_a), .frame_start(fs_a)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc_a)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_b (
    .pclk(pclk), .reset(rst_b), .en(en_b),
    .hsync(hs_b), .vsync(vs_b), .valid(val_b),
    .h_cnt(hc_b), .v_cnt(vc_b),
    .line_start(ls_b), .frame_start(fs_b)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc_b)
`endif
  );

  int checks = 0;
  int errors = 0;
  int posb = -1;
  int hs_n, hs_first, hs_last, vs_n, ls_n;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
    if (rst_b && en_b) posb = (posb + 1) % 84;
  endtask

  task automatic model_b();
    int x, y;
    x = posb % 12;
    y = posb / 12;
    chk("b_hs", 32'(hs_b), 32'(x == 9 || x == 10));
    chk("b_vs", 32'(vs_b), 32'(y == 5));
    chk("b_val", 32'(val_b), 32'(x < 8 && y < 4));
    chk("b_hc", 32'(hc_b), (x < 8) ? x : 0);
    chk("b_vc", 32'(vc_b), (y < 4) ? y : 0);
    chk("b_ls", 32'(ls_b), 32'(x == 0));
    chk("b_fs", 32'(fs_b), 32'(posb == 0));
  endtask

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog timeout");
  end

  initial begin
    rst_a = 1'b0; en_a = 1'b0;
    rst_b = 1'b0; en_b = 1'b0;
    repeat (3) step();

    chk("a_rst_hs", 32'(hs_a), 1);
    chk("a_rst_vs", 32'(vs_a), 1);
    chk("a_rst_val", 32'(val_a), 0);
    chk("a_rst_hc", 32'(hc_a), 0);
    chk("a_rst_ls", 32'(ls_a), 0);
    chk("a_rst_fs", 32'(fs_a), 0);
    chk("b_rst_hs", 32'(hs_b), 0);
    chk("b_rst_vs", 32'(vs_b), 0);

    rst_a = 1'b1; en_a = 1'b1;
    hs_n = 0; hs_first = 0; hs_last = 0; vs_n = 0; ls_n = 0;
    for (int c = 1; c <= 801; c++) begin
      step();
      if (!hs_a) begin
        hs_n++;
        if (hs_first == 0) hs_first = c;
        hs_last = c;
      end
      if (!vs_a) vs_n++;
      if (ls_a) ls_n++;
      if (c == 1) begin
        chk("a1_val", 32'(val_a), 1);
        chk("a1_hc", 32'(hc_a), 0);
        chk("a1_vc", 32'(vc_a), 0);
        chk("a1_ls", 32'(ls_a), 1);
        chk("a1_fs", 32'(fs_a), 1);
      end
      if (c == 640) begin
        chk("a640_hc", 32'(hc_a), 639);
        chk("a640_val", 32'(val_a), 1);
      end
      if (c == 641) begin
        chk("a641_val", 32'(val_a), 0);
        chk("a641_hc", 32'(hc_a), 0);
      end
      if (c == 801) begin
        chk("a801_ls", 32'(ls_a), 1);
        chk("a801_fs", 32'(fs_a), 0);
        chk("a801_vc", 32'(vc_a), 1);
        chk("a801_val", 32'(val_a), 1);
      end
    end
    chk("a_hs_len", hs_n, 96);
    chk("a_hs_first", hs_first, 657);
    chk("a_hs_last", hs_last, 752);
    chk("a_vs_len", vs_n, 0);
    chk("a_ls_n", ls_n, 2);

    rst_b = 1'b1; en_b = 1'b1;
    for (int c = 1; c <= 260; c++) begin
      step();
      model_b();
`ifdef VGA_TIMING_FRAME_CNT_EN
      chk("b_fc", 32'(fc_b), (c - 1) / 84);
`endif
    end

    repeat (84) if (posb != 23) step();
    chk("b_pre_stall_pos", posb, 23);
    en_b = 1'b0;
    repeat (5) begin
      step();
      chk("b_st_ls", 32'(ls_b), 0);
      chk("b_st_hc", 32'(hc_b), 0);
      chk("b_st_vc", 32'(vc_b), 1);
      chk("b_st_val", 32'(val_b), 0);
    end
    en_b = 1'b1;
    step();
    chk("b_res_ls", 32'(ls_b), 1);
    chk("b_res_vc", 32'(vc_b), 2);
    chk("b_res_val", 32'(val_b), 1);
    model_b();
    step();
    chk("b_res2_ls", 32'(ls_b), 0);
    chk("b_res2_hc", 32'(hc_b), 1);
    en_b = 1'b0;
    repeat (3) begin
      step();
      chk("b_st2_hc", 32'(hc_b), 1);
      chk("b_st2_val", 32'(val_b), 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
      chk("b_st2_fc", 32'(fc_b), 3);
`endif
    end
    en_b = 1'b1;
    step();
    chk("b_st2_end_hc", 32'(hc_b), 2);

    repeat (84) if (posb != 29) step();
    chk("b_pre_rst_hc", 32'(hc_b), 5);
    rst_b = 1'b0;
    #1;
    chk("b_arst_hs", 32'(hs_b), 0);
    chk("b_arst_vs", 32'(vs_b), 0);
    chk("b_arst_val", 32'(val_b), 0);
    chk("b_arst_hc", 32'(hc_b), 0);
    chk("b_arst_vc", 32'(vc_b), 0);
    chk("b_arst_ls", 32'(ls_b), 0);
    chk("b_arst_fs", 32'(fs_b), 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("b_arst_fc", 32'(fc_b), 0);
`endif
    #2;
    rst_b = 1'b1;
    posb = -1;
    step();
    chk("b_rel_fs", 32'(fs_b), 1);
    model_b();
    repeat (84) step();
    chk("b_rel2_fs", 32'(fs_b), 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("b_rel2_fc", 32'(fc_b), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
